// File: rtl/compander_arbiter.sv
// compander_arbiter: shares one compander pipeline among N_CAM camera lanes.
// Each lane has a small FIFO; a round-robin scheduler issues one patch per
// cycle (tagged with its lane index) while an in-flight credit counter bounds
// pipeline occupancy. halt drains the pipeline into HALTED; a credit underflow
// locks the block in ERROR until reset.
//
// Handshake: a lane word is accepted on a clock edge where in_valid[i] and
// in_ready[i] are both high; in_ready is registered and never depends on
// in_valid in the same cycle. in_valid while in_ready is low drops the word
// and sets the sticky overflow bit.
module compander_arbiter #(
    parameter int DELAY          = 1,
    parameter int N_CAM          = 3,
    parameter int PATCH_NUM_SIZE = 14,
    parameter int FP_SIZE        = 20,
    parameter int FIFO_DEPTH     = 16,
    parameter int MAX_INFLIGHT   = 32
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic [N_CAM-1:0]                              in_valid,
    input  logic [N_CAM*(PATCH_NUM_SIZE+FP_SIZE)-1:0]     in_data,
    output logic [N_CAM-1:0]                              in_ready,
    output logic                                          issue_valid,
    output logic [$clog2(N_CAM)-1:0]                      issue_cam,
    output logic [PATCH_NUM_SIZE+FP_SIZE-1:0]             issue_data,
    input  logic                                          ret_valid,
    input  logic                                          halt,
    output logic                                          halted,
    output logic                                          busy,
    output logic [$clog2(MAX_INFLIGHT):0]                 inflight,
    output logic [N_CAM-1:0]                              overflow,
    output logic                                          error
);

    localparam int W  = PATCH_NUM_SIZE + FP_SIZE;
    localparam int CW = $clog2(N_CAM);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    // DELAY only shapes simulated register timing; it has no hardware meaning.
    if (DELAY < 0) begin : g_negative_delay
    end

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_HALTED = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [W-1:0]     r_mem [N_CAM][FIFO_DEPTH];
    logic [AW-1:0]    r_wp  [N_CAM];
    logic [AW-1:0]    r_rp  [N_CAM];
    logic [AW:0]      r_cnt [N_CAM];
    logic [AW:0]      w_cnt_next [N_CAM];

    logic [CW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_inflight;
    logic [IW-1:0]    w_inflight_next;
    logic             r_issue_valid;
    logic [CW-1:0]    r_issue_cam;
    logic [W-1:0]     r_issue_data;
    logic [N_CAM-1:0] r_in_ready;
    logic [N_CAM-1:0] r_overflow;
    logic             r_busy;

    logic [N_CAM-1:0] w_wr;
    logic [N_CAM-1:0] w_rd;
    logic             w_found;
    logic             w_gnt;
    logic [CW-1:0]    w_gnt_lane;
    logic [CW-1:0]    w_idx;
    logic             w_underflow;
    logic             w_any_next;

    assign w_wr = in_valid & r_in_ready;

    // Round-robin search starting after the last granted lane; grant only in RUN with a free credit.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_lane = '0;
        w_idx      = '0;
        for (int k = 1; k <= N_CAM; k++) begin
            w_idx = CW'((int'(r_rr_ptr) + k) % N_CAM);
            if (!w_found && (r_cnt[w_idx] != '0)) begin
                w_found    = 1'b1;
                w_gnt_lane = w_idx;
            end
        end
        w_gnt = w_found && (r_state == S_RUN) && !halt && (r_inflight < IW'(MAX_INFLIGHT));
        w_rd  = '0;
        if (w_gnt) begin
            w_rd[w_gnt_lane] = 1'b1;
        end
    end

    // Credit bookkeeping; an unmatched return never decrements and trips ERROR instead.
    always_comb begin
        w_underflow     = ret_valid && (r_inflight == '0) && !w_gnt;
        w_inflight_next = r_inflight;
        if ((r_state != S_ERROR) && !w_underflow) begin
            if (w_gnt && !ret_valid) begin
                w_inflight_next = r_inflight + IW'(1);
            end else if (!w_gnt && ret_valid) begin
                w_inflight_next = r_inflight - IW'(1);
            end
        end
    end

    // Post-edge FIFO occupancy, used for in_ready and busy.
    always_comb begin
        w_any_next = 1'b0;
        for (int i = 0; i < N_CAM; i++) begin
            w_cnt_next[i] = r_cnt[i] + (AW+1)'(w_wr[i]) - (AW+1)'(w_rd[i]);
            if (w_cnt_next[i] != '0) begin
                w_any_next = 1'b1;
            end
        end
    end

    // Next-state logic; underflow overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_INIT:   w_state_next = S_RUN;
            S_RUN:    if (halt) w_state_next = S_DRAIN;
            S_DRAIN: begin
                if (!halt) begin
                    w_state_next = S_RUN;
                end else if (w_inflight_next == '0) begin
                    w_state_next = S_HALTED;
                end
            end
            S_HALTED: if (!halt) w_state_next = S_RUN;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_INIT;
        endcase
        if (w_underflow) begin
            w_state_next = S_ERROR;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lane FIFO storage; contents need no reset because pointers/counts gate them.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_CAM; i++) begin
            if (w_wr[i]) begin
                r_mem[i][r_wp[i]] <= in_data[i*W +: W];
            end
        end
    end

    // Lane FIFO pointers and counts.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_CAM; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CAM; i++) begin
                if (w_wr[i]) r_wp[i] <= r_wp[i] + AW'(1);
                if (w_rd[i]) r_rp[i] <= r_rp[i] + AW'(1);
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    // Issue register, round-robin pointer, credits, and registered status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_issue_valid <= 1'b0;
            r_issue_cam   <= '0;
            r_issue_data  <= '0;
            r_rr_ptr      <= CW'(N_CAM - 1);
            r_inflight    <= '0;
            r_in_ready    <= '0;
            r_overflow    <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_issue_valid <= w_gnt;
            if (w_gnt) begin
                r_issue_cam  <= w_gnt_lane;
                r_issue_data <= r_mem[w_gnt_lane][r_rp[w_gnt_lane]];
                r_rr_ptr     <= w_gnt_lane;
            end
            r_inflight <= w_inflight_next;
            r_overflow <= r_overflow | (in_valid & ~r_in_ready);
            for (int i = 0; i < N_CAM; i++) begin
                r_in_ready[i] <= (w_state_next != S_INIT) && (w_state_next != S_ERROR) &&
                                 (w_cnt_next[i] < (AW+1)'(FIFO_DEPTH));
            end
            r_busy <= (w_inflight_next != '0) || w_any_next;
        end
    end

    assign in_ready    = r_in_ready;
    assign issue_valid = r_issue_valid;
    assign issue_cam   = r_issue_cam;
    assign issue_data  = r_issue_data;
    assign halted      = (r_state == S_HALTED);
    assign error       = (r_state == S_ERROR);
    assign busy        = r_busy;
    assign inflight    = r_inflight;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_compander_arbiter.sv
// Bench for compander_arbiter: two instances (credit limit 32 and 4) share
// clock and reset. A queue-level model predicts every output each cycle;
// directed scenarios add literal expectations on top.
module tb_compander_arbiter;

    localparam int NC    = 3;
    localparam int PN    = 14;
    localparam int FPS   = 20;
    localparam int W     = PN + FPS;
    localparam int DEPTH = 16;

    localparam int M_INIT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_DRAIN  = 2;
    localparam int M_HALTED = 3;
    localparam int M_ERR    = 4;

    // clock / reset
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // per-instance stimulus and observation
    logic [NC-1:0]   in_valid    [2];
    logic [NC*W-1:0] in_data     [2];
    logic            ret_valid   [2];
    logic            halt        [2];
    logic [NC-1:0]   in_ready    [2];
    logic            issue_valid [2];
    logic [1:0]      issue_cam   [2];
    logic [W-1:0]    issue_data  [2];
    logic            halted      [2];
    logic            busy        [2];
    logic [NC-1:0]   overflow    [2];
    logic            error       [2];
    logic [5:0]      inf0;
    logic [2:0]      inf1;

    compander_arbiter #(.DELAY(1), .N_CAM(NC), .PATCH_NUM_SIZE(PN), .FP_SIZE(FPS),
                        .FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(32)) u_dut0 (
        .CLK(clk), .RESET(rst),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .issue_valid(issue_valid[0]), .issue_cam(issue_cam[0]), .issue_data(issue_data[0]),
        .ret_valid(ret_valid[0]), .halt(halt[0]), .halted(halted[0]), .busy(busy[0]),
        .inflight(inf0), .overflow(overflow[0]), .error(error[0])
    );

    compander_arbiter #(.DELAY(1), .N_CAM(NC), .PATCH_NUM_SIZE(PN), .FP_SIZE(FPS),
                        .FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(4)) u_dut1 (
        .CLK(clk), .RESET(rst),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .issue_valid(issue_valid[1]), .issue_cam(issue_cam[1]), .issue_data(issue_data[1]),
        .ret_valid(ret_valid[1]), .halt(halt[1]), .halted(halted[1]), .busy(busy[1]),
        .inflight(inf1), .overflow(overflow[1]), .error(error[1])
    );

    // counters
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // behavioural model: lane queues, credit count, mode
    logic [W-1:0]  exp_q [2][NC][$];
    int            m_mode [2];
    int            m_rr   [2];
    int            m_infl [2];
    logic [NC-1:0] m_ready [2];
    logic [NC-1:0] m_ovf   [2];
    logic          m_iv    [2];
    int            m_icam  [2];
    logic [W-1:0]  m_idata [2];
    logic          m_busy  [2];

    function automatic int max_of(input int d);
        return (d == 0) ? 32 : 4;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < NC; l++) exp_q[d][l].delete();
            m_mode[d]  = M_INIT;
            m_rr[d]    = NC - 1;
            m_infl[d]  = 0;
            m_ready[d] = '0;
            m_ovf[d]   = '0;
            m_iv[d]    = 1'b0;
            m_icam[d]  = 0;
            m_idata[d] = '0;
            m_busy[d]  = 1'b0;
        end
    endtask

    task automatic model_step(input int d);
        int lane;
        bit iss;
        bit under;
        int nm;
        bit any;
        lane = -1;
        if (m_mode[d] == M_RUN && !halt[d] && m_infl[d] < max_of(d)) begin
            for (int k = 1; k <= NC; k++) begin
                if (lane < 0 && exp_q[d][(m_rr[d] + k) % NC].size() != 0) lane = (m_rr[d] + k) % NC;
            end
        end
        iss = (lane >= 0);
        if (iss) begin
            m_idata[d] = exp_q[d][lane].pop_front();
            m_icam[d]  = lane;
            m_rr[d]    = lane;
        end
        m_iv[d] = iss;
        for (int l = 0; l < NC; l++) begin
            if (in_valid[d][l]) begin
                if (m_ready[d][l]) exp_q[d][l].push_back(in_data[d][l*W +: W]);
                else m_ovf[d][l] = 1'b1;
            end
        end
        under = ret_valid[d] && (m_infl[d] == 0) && !iss;
        if (m_mode[d] != M_ERR && !under) m_infl[d] = m_infl[d] + int'(iss) - int'(ret_valid[d]);
        if (under || m_mode[d] == M_ERR) nm = M_ERR;
        else begin
            case (m_mode[d])
                M_INIT:   nm = M_RUN;
                M_RUN:    nm = halt[d] ? M_DRAIN : M_RUN;
                M_DRAIN:  nm = !halt[d] ? M_RUN : ((m_infl[d] == 0) ? M_HALTED : M_DRAIN);
                default:  nm = !halt[d] ? M_RUN : M_HALTED;
            endcase
        end
        m_mode[d] = nm;
        any = (m_infl[d] != 0);
        for (int l = 0; l < NC; l++) begin
            m_ready[d][l] = (nm != M_INIT) && (nm != M_ERR) && (exp_q[d][l].size() < DEPTH);
            if (exp_q[d][l].size() != 0) any = 1'b1;
        end
        m_busy[d] = any;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d in_ready", d), 128'(in_ready[d]), 128'(m_ready[d]));
            chk($sformatf("d%0d issue_valid", d), 128'(issue_valid[d]), 128'(m_iv[d]));
            chk($sformatf("d%0d issue_cam", d), 128'(issue_cam[d]), 128'(m_icam[d]));
            chk($sformatf("d%0d issue_data", d), 128'(issue_data[d]), 128'(m_idata[d]));
            chk($sformatf("d%0d halted", d), 128'(halted[d]), 128'(m_mode[d] == M_HALTED));
            chk($sformatf("d%0d error", d), 128'(error[d]), 128'(m_mode[d] == M_ERR));
            chk($sformatf("d%0d busy", d), 128'(busy[d]), 128'(m_busy[d]));
            chk($sformatf("d%0d overflow", d), 128'(overflow[d]), 128'(m_ovf[d]));
            chk($sformatf("d%0d inflight", d), (d == 0) ? 128'(inf0) : 128'(inf1), 128'(m_infl[d]));
        end
    end

    // driver helpers
    int   iss_cnt0 = 0;
    int   iss_cnt1 = 0;
    bit   auto_ret = 1'b0;
    logic iv_hist[$];

    function automatic logic [NC*W-1:0] rand_slices();
        logic [NC*W-1:0] v;
        v = '0;
        for (int l = 0; l < NC; l++) v[l*W +: W] = W'({$urandom, $urandom});
        return v;
    endfunction

    // one clock: inputs change #1 after the edge; ret for DUT0 can follow issue_valid delayed 10 edges
    task automatic tick();
        @(posedge clk);
        #1;
        if (issue_valid[0]) iss_cnt0++;
        if (issue_valid[1]) iss_cnt1++;
        if (auto_ret) begin
            iv_hist.push_back(issue_valid[0]);
            ret_valid[0] = (iv_hist.size() >= 10) ? iv_hist[iv_hist.size() - 10] : 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int first;
        int last;
        int cyc;
        int cams [12];

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = '0;
            in_data[d]   = '0;
            ret_valid[d] = 1'b0;
            halt[d]      = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset / INIT
        chk("post-reset in_ready d0", 128'(in_ready[0]), 128'(0));
        chk("post-reset in_ready d1", 128'(in_ready[1]), 128'(0));
        chk("post-reset inflight d0", 128'(inf0), 128'(0));
        tick();
        chk("after INIT in_ready d0", 128'(in_ready[0]), 128'(3'b111));
        chk("after INIT in_ready d1", 128'(in_ready[1]), 128'(3'b111));

        // credit limit on DUT1 (MAX_INFLIGHT=4)
        iss_cnt1 = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid[1] = 3'b010;
            in_data[1]  = rand_slices();
            tick();
        end
        in_valid[1] = '0;
        repeat (10) tick();
        chk("credit issues", 128'(iss_cnt1), 128'(4));
        chk("credit inflight", 128'(inf1), 128'(4));
        ret_valid[1] = 1'b1;
        tick();
        ret_valid[1] = 1'b0;
        chk("credit no bypass", 128'(issue_valid[1]), 128'(0));
        chk("credit after ret", 128'(inf1), 128'(3));
        tick();
        chk("credit reissue", 128'(issue_valid[1]), 128'(1));
        chk("credit refill", 128'(inf1), 128'(4));
        repeat (5) tick();
        chk("credit total issues", 128'(iss_cnt1), 128'(5));

        // randomized traffic on DUT1, returns only while the model holds credits
        for (int c = 0; c < 300; c++) begin
            for (int l = 0; l < NC; l++)
                in_valid[1][l] = ($urandom_range(0, 3) != 0) && (in_ready[1][l] || ($urandom_range(0, 9) == 0));
            in_data[1] = rand_slices();
            if ($urandom_range(0, 15) == 0) halt[1] = ~halt[1];
            ret_valid[1] = (m_infl[1] > 0) && ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid[1]  = '0;
        ret_valid[1] = 1'b0;
        halt[1]      = 1'b0;

        // round-robin on DUT0: preload 4 per lane while halted, then release
        halt[0] = 1'b1;
        repeat (3) tick();
        chk("rr preload halted", 128'(halted[0]), 128'(1));
        for (int k = 0; k < 4; k++) begin
            in_valid[0] = 3'b111;
            in_data[0]  = rand_slices();
            tick();
        end
        in_valid[0] = '0;
        iv_hist.delete();
        auto_ret = 1'b1;
        halt[0]  = 1'b0;
        n = 0; first = -1; last = -1; cyc = 0;
        while (n < 12 && cyc < 40) begin
            tick();
            cyc++;
            if (issue_valid[0]) begin
                cams[n] = int'(issue_cam[0]);
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
        end
        chk("rr issue count", 128'(n), 128'(12));
        chk("rr consecutive", 128'(last - first), 128'(11));
        for (int k = 0; k < 12; k++) chk($sformatf("rr cam %0d", k), 128'(cams[k]), 128'(k % 3));
        cyc = 0;
        while (inf0 != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("rr drained inflight", 128'(inf0), 128'(0));
        auto_ret     = 1'b0;
        ret_valid[0] = 1'b0;

        // FIFO full / overflow on lane 2 while halted
        halt[0] = 1'b1;
        repeat (3) tick();
        chk("ovf halted", 128'(halted[0]), 128'(1));
        for (int k = 1; k <= 17; k++) begin
            in_valid[0] = 3'b100;
            in_data[0]  = rand_slices();
            tick();
            if (k == 15) chk("ovf ready at 15", 128'(in_ready[0]), 128'(3'b111));
            if (k == 16) chk("ovf ready at 16", 128'(in_ready[0]), 128'(3'b011));
        end
        in_valid[0] = '0;
        chk("ovf sticky", 128'(overflow[0]), 128'(3'b100));
        chk("ovf other lanes ready", 128'(in_ready[0]), 128'(3'b011));

        // drain: reach inflight 3, halt, return 3 spaced by 2 cycles
        halt[0] = 1'b0;
        cyc = 0;
        while (inf0 != 3 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drain start inflight", 128'(inf0), 128'(3));
        halt[0]  = 1'b1;
        iss_cnt0 = 0;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) begin
            ret_valid[0] = 1'b1;
            tick();
            ret_valid[0] = 1'b0;
            chk($sformatf("drain halted after ret %0d", r), 128'(halted[0]), 128'(r == 2));
            tick();
        end
        chk("drain no issues", 128'(iss_cnt0), 128'(0));
        chk("drain inflight", 128'(inf0), 128'(0));
        halt[0] = 1'b0;
        tick();
        chk("resume halted low", 128'(halted[0]), 128'(0));
        chk("resume no issue yet", 128'(issue_valid[0]), 128'(0));
        tick();
        chk("resume issue", 128'(issue_valid[0]), 128'(1));

        // reset mid-burst with inflight 5
        cyc = 0;
        while (inf0 != 5 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("burst inflight", 128'(inf0), 128'(5));
        #2 rst = 1'b1;
        #1;
        chk("async rst issue_valid", 128'(issue_valid[0]), 128'(0));
        chk("async rst issue_cam", 128'(issue_cam[0]), 128'(0));
        chk("async rst issue_data", 128'(issue_data[0]), 128'(0));
        chk("async rst inflight", 128'(inf0), 128'(0));
        chk("async rst in_ready", 128'(in_ready[0]), 128'(0));
        chk("async rst overflow", 128'(overflow[0]), 128'(0));
        chk("async rst busy", 128'(busy[0]), 128'(0));
        chk("async rst halted", 128'(halted[0]), 128'(0));
        tick();
        rst = 1'b0;
        chk("release in_ready low", 128'(in_ready[0]), 128'(0));
        tick();
        chk("release in_ready high", 128'(in_ready[0]), 128'(3'b111));
        chk("release inflight", 128'(inf0), 128'(0));

        // underflow locks ERROR
        ret_valid[0] = 1'b1;
        tick();
        ret_valid[0] = 1'b0;
        chk("underflow error", 128'(error[0]), 128'(1));
        chk("underflow in_ready", 128'(in_ready[0]), 128'(0));
        in_valid[0] = 3'b001;
        in_data[0]  = rand_slices();
        tick();
        in_valid[0] = '0;
        iss_cnt0 = 0;
        repeat (5) tick();
        chk("error no issues", 128'(iss_cnt0), 128'(0));
        chk("error sticky", 128'(error[0]), 128'(1));
        chk("error write dropped", 128'(overflow[0]), 128'(3'b001));

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
